// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter for the SDRAM controller host port.
// Fair write/read alternation, high-water-mark zero fill and watchdog abort.
module sdram_port_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clear,
  output logic [ADDR_W:0]   hwm,
  output logic              err_timeout,
  output logic              ctrl_wr_enable,
  output logic              ctrl_rd_enable,
  output logic [ADDR_W-1:0] ctrl_wr_addr,
  output logic [ADDR_W-1:0] ctrl_rd_addr,
  output logic [DATA_W-1:0] ctrl_wr_data,
  input  logic [DATA_W-1:0] ctrl_rd_data,
  input  logic              ctrl_rd_ready,
  input  logic              ctrl_busy
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state, state_d;
  logic              busy_q;
  logic              last_wr;
  logic              cur_wr;
  logic              wr_abort;
  logic [WD_W-1:0]   wdog;
  logic [DATA_W-1:0] result;
  logic              grant_wr, grant_rd;
  logic              hit, zfill, active, expire;
  logic [ADDR_W:0]   wr_end;

  assign hit    = {1'b0, rd_addr} < hwm;
  assign zfill  = grant_rd && !hit;
  assign active = (state == ISSUE) || (state == WAIT);
  assign expire = active && (wdog == WD_W'(TIMEOUT - 1));
  assign wr_end = {1'b0, ctrl_wr_addr} + (ADDR_W+1)'(1);

  always_comb begin
    state_d  = state;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    unique case (state)
      IDLE: begin
        grant_wr = wr_req && (!rd_req || !last_wr);
        grant_rd = rd_req && !grant_wr;
        if (grant_wr)
          state_d = ISSUE;
        else if (grant_rd)
          state_d = hit ? ISSUE : DONE;
      end
      ISSUE: begin
        if (expire)
          state_d = DONE;
        else if (busy_q)
          state_d = WAIT;
      end
      WAIT: begin
        if (expire || !busy_q)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q         <= 1'b0;
      last_wr        <= 1'b0;
      cur_wr         <= 1'b0;
      wr_abort       <= 1'b0;
      wdog           <= '0;
      result         <= '0;
      wr_ack         <= 1'b0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      hwm            <= '0;
      err_timeout    <= 1'b0;
      ctrl_wr_enable <= 1'b0;
      ctrl_rd_enable <= 1'b0;
      ctrl_wr_addr   <= '0;
      ctrl_rd_addr   <= '0;
      ctrl_wr_data   <= '0;
    end else begin
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      busy_q   <= ctrl_busy;
      wdog     <= active ? wdog + 1'b1 : '0;
      if (grant_wr) begin
        last_wr        <= 1'b1;
        cur_wr         <= 1'b1;
        ctrl_wr_addr   <= wr_addr;
        ctrl_wr_data   <= wr_data;
        ctrl_wr_enable <= 1'b1;
      end
      if (grant_rd) begin
        last_wr        <= 1'b0;
        cur_wr         <= 1'b0;
        ctrl_rd_addr   <= rd_addr;
        result         <= '0;
        ctrl_rd_enable <= hit;
      end
      if (zfill) begin
        rd_valid <= 1'b1;
        rd_data  <= '0;
      end
      if ((state == ISSUE && busy_q) || expire) begin
        ctrl_wr_enable <= 1'b0;
        ctrl_rd_enable <= 1'b0;
      end
      if (state == WAIT && !cur_wr && ctrl_rd_ready)
        result <= ctrl_rd_data;
      // forward a ready that lands on the last WAIT cycle
      if (active && state_d == DONE) begin
        wr_abort <= expire;
        if (cur_wr) begin
          wr_ack <= 1'b1;
        end else begin
          rd_valid <= 1'b1;
          if (expire)
            rd_data <= '0;
          else if (state == WAIT && ctrl_rd_ready)
            rd_data <= ctrl_rd_data;
          else
            rd_data <= result;
        end
      end
      if (expire)
        err_timeout <= 1'b1;
      if (state == DONE && cur_wr && !wr_abort && wr_end > hwm)
        hwm <= wr_end;
      if (clear) begin
        hwm         <= '0;
        err_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: transaction model plus a per-cycle compare.
// A small controller model answers the enable/busy handshake.
module tb_sdram_port_arbiter;

  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int TO    = 20;
  localparam int E_LAT = 1;
  localparam int B_LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_req, rd_req, clear;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack, rd_valid, err_timeout;
  logic [DW-1:0] rd_data;
  logic [AW:0]   hwm;
  logic          ctrl_wr_enable, ctrl_rd_enable;
  logic [AW-1:0] ctrl_wr_addr, ctrl_rd_addr;
  logic [DW-1:0] ctrl_wr_data;
  logic [DW-1:0] ctrl_rd_data;
  logic          ctrl_rd_ready, ctrl_busy;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .clear(clear), .hwm(hwm), .err_timeout(err_timeout),
    .ctrl_wr_enable(ctrl_wr_enable), .ctrl_rd_enable(ctrl_rd_enable),
    .ctrl_wr_addr(ctrl_wr_addr), .ctrl_rd_addr(ctrl_rd_addr),
    .ctrl_wr_data(ctrl_wr_data),
    .ctrl_rd_data(ctrl_rd_data), .ctrl_rd_ready(ctrl_rd_ready),
    .ctrl_busy(ctrl_busy)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // transaction-level model state
  logic [DW-1:0] m_mem [int];
  logic [AW:0]   m_hwm = '0;
  logic [DW-1:0] m_rd = '0;
  logic          m_err = 1'b0;
  logic          m_last_wr = 1'b0;
  logic [AW:0]   exp_wr_end = '0;
  logic          exp_to = 1'b0;
  logic [DW-1:0] exp_rd = '0;
  bit            run = 1'b0;
  int            rd_en_rises = 0;
  int            wr_en_cycles = 0;
  logic          prev_rd_en = 1'b0;
  logic          prev_wr_ack = 1'b0;
  logic          prev_rd_valid = 1'b0;

  // SDRAM controller model: busy E_LAT cycles after enable, for B_LAT cycles
  logic [DW-1:0] c_mem [int];
  int            cst = 0;
  int            ccnt = 0;
  int            stuck_n = 0;
  logic          c_rd = 1'b0;
  logic [AW-1:0] c_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cst = 0;
      ctrl_busy = 1'b0;
      ctrl_rd_ready = 1'b0;
    end else if (stuck_n > 0) begin
      ctrl_busy = 1'b1;
      stuck_n--;
    end else begin
      case (cst)
        0: begin
          ctrl_busy = 1'b0;
          if (ctrl_wr_enable || ctrl_rd_enable) begin
            c_rd = ctrl_rd_enable;
            c_addr = c_rd ? ctrl_rd_addr : ctrl_wr_addr;
            if (!c_rd)
              c_mem[int'(c_addr)] = ctrl_wr_data;
            ccnt = E_LAT;
            cst = 1;
          end
        end
        1: begin
          ccnt--;
          if (ccnt == 0) begin
            ctrl_busy = 1'b1;
            ccnt = B_LAT;
            cst = 2;
          end
        end
        default: begin
          ccnt--;
          ctrl_rd_ready = c_rd && (ccnt == 1);
          if (ctrl_rd_ready)
            ctrl_rd_data = c_mem.exists(int'(c_addr)) ?
                           c_mem[int'(c_addr)] : 16'hDEAD;
          if (ccnt == 0) begin
            ctrl_busy = 1'b0;
            ctrl_rd_ready = 1'b0;
            cst = 0;
          end
        end
      endcase
    end
  end

  // per-cycle compare just after each active edge
  always @(posedge clk) begin
    #1;
    if (run) begin
      if (prev_wr_ack && !exp_to && exp_wr_end > m_hwm)
        m_hwm = exp_wr_end;
      if ((wr_ack || rd_valid) && exp_to)
        m_err = 1'b1;
      if (clear) begin
        m_hwm = '0;
        m_err = 1'b0;
      end
      if (rd_valid)
        m_rd = exp_rd;
      if (ctrl_rd_enable && !prev_rd_en)
        rd_en_rises++;
      if (ctrl_wr_enable)
        wr_en_cycles++;
      check("hwm", 32'(hwm), 32'(m_hwm));
      check("err_timeout", 32'(err_timeout), 32'(m_err));
      check("rd_data", 32'(rd_data), 32'(m_rd));
      check("exclusive", 32'((wr_ack && rd_valid) ||
            (ctrl_wr_enable && ctrl_rd_enable)), 32'(0));
      check("pulse_width", 32'((wr_ack && prev_wr_ack) ||
            (rd_valid && prev_rd_valid)), 32'(0));
      prev_rd_en    = ctrl_rd_enable;
      prev_wr_ack   = wr_ack;
      prev_rd_valid = rd_valid;
    end
  end

  task automatic do_access(input bit is_wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input bit to,
                           input bit clr_done, output int lat);
    int exp_lat;
    bit zf;
    zf = 1'b0;
    if (is_wr) begin
      exp_wr_end = {1'b0, addr} + (AW+1)'(1);
      if (!to)
        m_mem[int'(addr)] = data;
      exp_lat = to ? TO + 1 : 3 + E_LAT + B_LAT;
    end else begin
      zf = ({1'b0, addr} >= m_hwm);
      exp_rd = zf ? '0 : (m_mem.exists(int'(addr)) ?
                          m_mem[int'(addr)] : 16'hDEAD);
      exp_lat = zf ? 1 : 3 + E_LAT + B_LAT;
    end
    exp_to = to;
    m_last_wr = is_wr;
    rd_en_rises = 0;
    wr_en_cycles = 0;
    if (is_wr) begin
      wr_addr = addr;
      wr_data = data;
      wr_req = 1'b1;
    end else begin
      rd_addr = addr;
      rd_req = 1'b1;
    end
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if ((is_wr && wr_ack) || (!is_wr && rd_valid)) begin
        lat = i;
        break;
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    if (clr_done)
      clear = 1'b1;
    check(is_wr ? "wr_latency" : "rd_latency", 32'(lat), 32'(exp_lat));
    if (is_wr && !to)
      check("wr_en_cycles", 32'(wr_en_cycles), 32'(E_LAT + 2));
    if (!is_wr)
      check("rd_en_rises", 32'(rd_en_rises), zf ? 32'(0) : 32'(1));
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic contend(input int n);
    string got;
    string want;
    bit    nxt_wr;
    int    nw, nr;
    got = "";
    want = "";
    nxt_wr = !m_last_wr;
    nw = 0;
    nr = 0;
    wr_addr = 24'd5;
    wr_data = 16'h0055;
    rd_addr = 24'd1;
    exp_wr_end = 25'd6;
    exp_to = 1'b0;
    exp_rd = m_mem[1];
    m_mem[5] = 16'h0055;
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      want = {want, nxt_wr ? "W" : "R"};
      m_last_wr = nxt_wr;
      nxt_wr = !nxt_wr;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (wr_ack || rd_valid)
          break;
      end
      if (wr_ack) begin
        got = {got, "W"};
        nw++;
      end else if (rd_valid) begin
        got = {got, "R"};
        nr++;
      end else begin
        got = {got, "-"};
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    nchk++;
    if (got != want) begin
      nerr++;
      $display("FAIL grant_order: got %s expected %s", got, want);
    end
    nchk++;
    if (got != "WRWR") begin
      nerr++;
      $display("FAIL grant_pin: got %s expected WRWR", got);
    end
    check("contend_wr_acks", 32'(nw), 32'(2));
    check("contend_rd_valids", 32'(nr), 32'(2));
  endtask

  int lat;

  initial begin
    rst_n = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    clear = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;
    ctrl_busy = 1'b0;
    ctrl_rd_ready = 1'b0;
    ctrl_rd_data = '0;
    repeat (3) @(negedge clk);
    check("rst_wr_ack", 32'(wr_ack), 32'(0));
    check("rst_rd_valid", 32'(rd_valid), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    check("rst_hwm", 32'(hwm), 32'(0));
    check("rst_err", 32'(err_timeout), 32'(0));
    check("rst_enables", 32'({ctrl_wr_enable, ctrl_rd_enable}), 32'(0));
    check("rst_ctrl_addr", 32'(ctrl_wr_addr | ctrl_rd_addr), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;

    do_access(1'b1, 24'd0, 16'h00A5, 1'b0, 1'b0, lat);
    check("hwm_first", 32'(hwm), 32'(1));

    for (int a = 0; a < 4; a++)
      do_access(1'b1, AW'(a), DW'(16'h11 * (a + 1)), 1'b0, 1'b0, lat);
    do_access(1'b0, 24'd2, '0, 1'b0, 1'b0, lat);
    check("rd2_data", 32'(rd_data), 32'h0033);
    check("hwm_four", 32'(hwm), 32'(4));

    do_access(1'b0, 24'd4, '0, 1'b0, 1'b0, lat);
    check("zf_data", 32'(rd_data), 32'(0));
    check("zf_lat", 32'(lat), 32'(1));

    contend(4);
    check("hwm_contend", 32'(hwm), 32'(6));

    stuck_n = TO + 10;
    @(negedge clk);
    do_access(1'b1, 24'd7, 16'hBEEF, 1'b1, 1'b0, lat);
    check("to_err", 32'(err_timeout), 32'(1));
    check("to_hwm_kept", 32'(hwm), 32'(6));
    repeat (15) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_err", 32'(err_timeout), 32'(0));
    check("clr_hwm", 32'(hwm), 32'(0));

    do_access(1'b1, 24'hFFFFFF, 16'h1234, 1'b0, 1'b0, lat);
    check("hwm_top", 32'(hwm), 32'h1000000);
    do_access(1'b1, 24'h000010, 16'h0077, 1'b0, 1'b1, lat);
    check("hwm_clear_wins", 32'(hwm), 32'(0));
    do_access(1'b0, 24'd0, '0, 1'b0, 1'b0, lat);
    check("zf_after_clear", 32'(lat), 32'(1));

    wr_addr = 24'd9;
    wr_data = 16'h0099;
    wr_req = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_reset_en", 32'(ctrl_wr_enable), 32'(1));
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_en", 32'(ctrl_wr_enable), 32'(0));
    check("async_rst_hwm", 32'(hwm), 32'(0));
    wr_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
